// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for mem_arbiter: state and owner codes, idle bytemode, default hold length.
package mem_arbiter_pkg;

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] ACCESS = 2'd1;
   localparam logic [1:0] DONE   = 2'd2;

   localparam logic OWN_IF  = 1'b0;
   localparam logic OWN_MEM = 1'b1;

   localparam logic [4:0] BM_WORD = 5'b01111;
   localparam int ACCESS_CYCLES_DEFAULT = 2;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [4:0]  bytemode;
      logic        we;
   } req_t;

endpackage

// File: rtl/mem_arbiter.sv
// Fetch/data arbiter for the single MMU port; MEM-first, or round robin with MEM_ARBITER_ROUND_ROBIN_EN.
// Ack comes ACCESS_CYCLES+1 cycles after grant; requesters hold req level until their ack pulse.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int ACCESS_CYCLES = ACCESS_CYCLES_DEFAULT,
   parameter int CNT_W         = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic [31:0] if_rdata,
   output logic        if_ack,
   input  logic        mem_req,
   input  logic        mem_we,
   input  logic [31:0] mem_addr,
   input  logic [31:0] mem_wdata,
   input  logic [4:0]  mem_bytemode,
   output logic [31:0] mem_rdata,
   output logic        mem_ack,
   output logic        busy,
   output logic        mmu_read,
   output logic        mmu_write,
   output logic [31:0] mmu_addr,
   output logic [31:0] mmu_wdata,
   output logic [4:0]  mmu_bytemode,
   input  logic [31:0] mmu_rdata
);

   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             owner_q, owner_d;
   req_t             req_q, req_d;
   logic [31:0]      if_rdata_q, if_rdata_d;
   logic [31:0]      mem_rdata_q, mem_rdata_d;
   logic             grant_mem;
   logic             in_access;

`ifdef MEM_ARBITER_ROUND_ROBIN_EN
   logic last_grant_q, last_grant_d;
   // On contention the port that lost last time wins; a lone requester always wins.
   assign grant_mem = mem_req & (~if_req | (last_grant_q == OWN_IF));
`else
   assign grant_mem = mem_req;
`endif

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      owner_d     = owner_q;
      req_d       = req_q;
      if_rdata_d  = if_rdata_q;
      mem_rdata_d = mem_rdata_q;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
      last_grant_d = last_grant_q;
`endif
      case (state_q)
         IDLE: begin
            if (mem_req || if_req) begin
               if (grant_mem) begin
                  owner_d        = OWN_MEM;
                  req_d.addr     = mem_addr;
                  req_d.wdata    = mem_wdata;
                  req_d.bytemode = mem_bytemode;
                  req_d.we       = mem_we;
               end else begin
                  owner_d        = OWN_IF;
                  req_d.addr     = if_addr;
                  req_d.wdata    = 32'd0;
                  req_d.bytemode = BM_WORD;
                  req_d.we       = 1'b0;
               end
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
               last_grant_d = grant_mem ? OWN_MEM : OWN_IF;
`endif
               cnt_d   = CNT_W'(ACCESS_CYCLES - 1);
               state_d = ACCESS;
            end
         end
         ACCESS: begin
            if (cnt_q == '0) begin
               if (!req_q.we) begin
                  if (owner_q == OWN_MEM) mem_rdata_d = mmu_rdata;
                  else                    if_rdata_d  = mmu_rdata;
               end
               state_d = DONE;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         owner_q     <= OWN_IF;
         req_q       <= '0;
         if_rdata_q  <= '0;
         mem_rdata_q <= '0;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
         last_grant_q <= OWN_IF;
`endif
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         owner_q     <= owner_d;
         req_q       <= req_d;
         if_rdata_q  <= if_rdata_d;
         mem_rdata_q <= mem_rdata_d;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
         last_grant_q <= last_grant_d;
`endif
      end
   end

   // MMU inputs are driven only from latched state so they stay stable across the whole access.
   assign in_access    = (state_q == ACCESS);
   assign mmu_read     = in_access & ~req_q.we;
   assign mmu_write    = in_access & req_q.we;
   assign mmu_addr     = in_access ? req_q.addr : 32'd0;
   assign mmu_wdata    = in_access ? req_q.wdata : 32'd0;
   assign mmu_bytemode = in_access ? req_q.bytemode : BM_WORD;

   assign busy      = (state_q != IDLE);
   assign if_ack    = (state_q == DONE) && (owner_q == OWN_IF);
   assign mem_ack   = (state_q == DONE) && (owner_q == OWN_MEM);
   assign if_rdata  = if_rdata_q;
   assign mem_rdata = mem_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: cycle table on a 2-cycle instance, hand sequence on a 1-cycle instance.
module tb_mem_arbiter;

`ifdef MEM_ARBITER_ROUND_ROBIN_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset, if_req, mem_req, mem_we;
   logic [31:0] if_addr, mem_addr, mem_wdata, mmu_rdata;
   logic [4:0]  mem_bytemode;
   logic [31:0] if_rdata, mem_rdata, mmu_addr, mmu_wdata;
   logic        if_ack, mem_ack, busy, mmu_read, mmu_write;
   logic [4:0]  mmu_bytemode;

   logic        b_reset, b_if_req, b_mem_req, b_mem_we;
   logic [31:0] b_if_addr, b_mem_addr, b_mem_wdata, b_mmu_rdata;
   logic [4:0]  b_mem_bytemode;
   logic [31:0] b_if_rdata, b_mem_rdata, b_mmu_addr, b_mmu_wdata;
   logic        b_if_ack, b_mem_ack, b_busy, b_mmu_read, b_mmu_write;
   logic [4:0]  b_mmu_bytemode;

   mem_arbiter #(.ACCESS_CYCLES(2), .CNT_W(4)) dut (
      .clk(clk), .reset(reset), .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_bytemode(mem_bytemode), .mem_rdata(mem_rdata), .mem_ack(mem_ack), .busy(busy),
      .mmu_read(mmu_read), .mmu_write(mmu_write), .mmu_addr(mmu_addr), .mmu_wdata(mmu_wdata),
      .mmu_bytemode(mmu_bytemode), .mmu_rdata(mmu_rdata)
   );

   mem_arbiter #(.ACCESS_CYCLES(1), .CNT_W(4)) dut1 (
      .clk(clk), .reset(b_reset), .if_req(b_if_req), .if_addr(b_if_addr), .if_rdata(b_if_rdata), .if_ack(b_if_ack),
      .mem_req(b_mem_req), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
      .mem_bytemode(b_mem_bytemode), .mem_rdata(b_mem_rdata), .mem_ack(b_mem_ack), .busy(b_busy),
      .mmu_read(b_mmu_read), .mmu_write(b_mmu_write), .mmu_addr(b_mmu_addr), .mmu_wdata(b_mmu_wdata),
      .mmu_bytemode(b_mmu_bytemode), .mmu_rdata(b_mmu_rdata)
   );

   typedef struct {
      logic        rst, ifr;
      logic [31:0] ifa;
      logic        mr, mwe;
      logic [31:0] ma, mwd;
      logic [4:0]  mbm;
      logic [31:0] rd;
      logic        ia, mack, bsy, rdo, wro;
      logic [31:0] addr, wdata;
      logic [4:0]  bm;
      logic [31:0] ird, mrd;
   } vec_t;

   localparam int NV = 25;
   vec_t tbl [NV];
   int checks = 0;
   int errors = 0;

   function automatic vec_t v(input logic rst, ifr, input logic [31:0] ifa, input logic mr, mwe,
                              input logic [31:0] ma, mwd, input logic [4:0] mbm, input logic [31:0] rd,
                              input logic ia, mack, bsy, rdo, wro, input logic [31:0] addr, wdata,
                              input logic [4:0] bm, input logic [31:0] ird, mrd);
      vec_t r;
      r.rst = rst; r.ifr = ifr; r.ifa = ifa; r.mr = mr; r.mwe = mwe; r.ma = ma; r.mwd = mwd;
      r.mbm = mbm; r.rd = rd; r.ia = ia; r.mack = mack; r.bsy = bsy; r.rdo = rdo; r.wro = wro;
      r.addr = addr; r.wdata = wdata; r.bm = bm; r.ird = ird; r.mrd = mrd;
      return r;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   initial begin
      logic [31:0] i1, ird14, mrd14, ird18, mrd18, a_first, a_second;
      i1       = 32'h3C08BFD0;
      a_first  = RR ? 32'h80000004 : 32'h80400020;
      a_second = RR ? 32'h80400020 : 32'h80000004;
      ird14    = RR ? 32'h12345678 : i1;
      mrd14    = RR ? 32'h00000000 : 32'h12345678;
      ird18    = RR ? 32'h12345678 : 32'hAAAA5555;
      mrd18    = RR ? 32'hAAAA5555 : 32'h12345678;

      // reset state
      tbl[0]  = v(0,0,0,0,0,0,0,5'h0F,0,                               0,0,0,0,0,0,0,5'h0F,0,0);
      // fetch, 2-cycle hold, ack on the 3rd cycle after the request is seen
      tbl[1]  = v(0,1,32'h80000000,0,0,0,0,5'h0F,i1,                   0,0,0,0,0,0,0,5'h0F,0,0);
      tbl[2]  = v(0,1,32'h80000000,0,0,0,0,5'h0F,i1,                   0,0,1,1,0,32'h80000000,0,5'h0F,0,0);
      tbl[3]  = v(0,1,32'h80000000,0,0,0,0,5'h0F,i1,                   0,0,1,1,0,32'h80000000,0,5'h0F,0,0);
      tbl[4]  = v(0,1,32'h80000000,0,0,0,0,5'h0F,i1,                   1,0,1,0,0,0,0,5'h0F,i1,0);
      tbl[5]  = v(0,0,0,0,0,0,0,5'h0F,0,                               0,0,0,0,0,0,0,5'h0F,i1,0);
      // data write; inputs change mid-access and must be ignored
      tbl[6]  = v(0,0,0,1,1,32'h80400010,32'hA5,5'h01,32'hDEADBEEF,    0,0,0,0,0,0,0,5'h0F,i1,0);
      tbl[7]  = v(0,0,0,1,1,32'h11111111,32'hFFFFFFFF,5'h1F,32'hDEADBEEF, 0,0,1,0,1,32'h80400010,32'hA5,5'h01,i1,0);
      tbl[8]  = v(0,0,0,1,1,32'h11111111,32'hFFFFFFFF,5'h1F,32'hDEADBEEF, 0,0,1,0,1,32'h80400010,32'hA5,5'h01,i1,0);
      tbl[9]  = v(0,0,0,1,1,32'h11111111,32'hFFFFFFFF,5'h1F,32'hDEADBEEF, 0,1,1,0,0,0,0,5'h0F,i1,0);
      tbl[10] = v(0,0,0,0,0,0,0,5'h0F,0,                               0,0,0,0,0,0,0,5'h0F,i1,0);
      // simultaneous requests
      tbl[11] = v(0,1,32'h80000004,1,0,32'h80400020,0,5'h0F,32'h12345678, 0,0,0,0,0,0,0,5'h0F,i1,0);
      tbl[12] = v(0,1,32'h80000004,1,0,32'h80400020,0,5'h0F,32'h12345678, 0,0,1,1,0,a_first,0,5'h0F,i1,0);
      tbl[13] = v(0,1,32'h80000004,1,0,32'h80400020,0,5'h0F,32'h12345678, 0,0,1,1,0,a_first,0,5'h0F,i1,0);
      tbl[14] = v(0,1,32'h80000004,1,0,32'h80400020,0,5'h0F,32'h12345678, RR,!RR,1,0,0,0,0,5'h0F,ird14,mrd14);
      tbl[15] = v(0,!RR,32'h80000004,RR,0,32'h80400020,0,5'h0F,32'hAAAA5555, 0,0,0,0,0,0,0,5'h0F,ird14,mrd14);
      tbl[16] = v(0,!RR,32'h80000004,RR,0,32'h80400020,0,5'h0F,32'hAAAA5555, 0,0,1,1,0,a_second,0,5'h0F,ird14,mrd14);
      tbl[17] = v(0,!RR,32'h80000004,RR,0,32'h80400020,0,5'h0F,32'hAAAA5555, 0,0,1,1,0,a_second,0,5'h0F,ird14,mrd14);
      tbl[18] = v(0,!RR,32'h80000004,RR,0,32'h80400020,0,5'h0F,32'hAAAA5555, !RR,RR,1,0,0,0,0,5'h0F,ird18,mrd18);
      tbl[19] = v(0,0,0,0,0,0,0,5'h0F,0,                               0,0,0,0,0,0,0,5'h0F,ird18,mrd18);
      // reset in the second access cycle of a data read
      tbl[20] = v(0,0,0,1,0,32'h80400030,0,5'h0F,32'h55555555,         0,0,0,0,0,0,0,5'h0F,ird18,mrd18);
      tbl[21] = v(0,0,0,1,0,32'h80400030,0,5'h0F,32'h55555555,         0,0,1,1,0,32'h80400030,0,5'h0F,ird18,mrd18);
      tbl[22] = v(1,0,0,1,0,32'h80400030,0,5'h0F,32'h55555555,         0,0,1,1,0,32'h80400030,0,5'h0F,ird18,mrd18);
      tbl[23] = v(0,0,0,0,0,0,0,5'h0F,32'h55555555,                    0,0,0,0,0,0,0,5'h0F,0,0);
      tbl[24] = v(0,0,0,0,0,0,0,5'h0F,32'h55555555,                    0,0,0,0,0,0,0,5'h0F,0,0);

      reset = 1'b1; if_req = 1'b0; if_addr = '0; mem_req = 1'b0; mem_we = 1'b0;
      mem_addr = '0; mem_wdata = '0; mem_bytemode = 5'h0F; mmu_rdata = '0;
      b_reset = 1'b1; b_if_req = 1'b0; b_if_addr = '0; b_mem_req = 1'b0; b_mem_we = 1'b0;
      b_mem_addr = '0; b_mem_wdata = '0; b_mem_bytemode = 5'h0F; b_mmu_rdata = '0;
      repeat (2) @(posedge clk);

      for (int i = 0; i < NV; i++) begin
         @(negedge clk);
         reset = tbl[i].rst; if_req = tbl[i].ifr; if_addr = tbl[i].ifa;
         mem_req = tbl[i].mr; mem_we = tbl[i].mwe; mem_addr = tbl[i].ma;
         mem_wdata = tbl[i].mwd; mem_bytemode = tbl[i].mbm; mmu_rdata = tbl[i].rd;
         #1;
         chk($sformatf("row%0d if_ack", i),       32'(if_ack),       32'(tbl[i].ia));
         chk($sformatf("row%0d mem_ack", i),      32'(mem_ack),      32'(tbl[i].mack));
         chk($sformatf("row%0d busy", i),         32'(busy),         32'(tbl[i].bsy));
         chk($sformatf("row%0d mmu_read", i),     32'(mmu_read),     32'(tbl[i].rdo));
         chk($sformatf("row%0d mmu_write", i),    32'(mmu_write),    32'(tbl[i].wro));
         chk($sformatf("row%0d mmu_addr", i),     mmu_addr,          tbl[i].addr);
         chk($sformatf("row%0d mmu_wdata", i),    mmu_wdata,         tbl[i].wdata);
         chk($sformatf("row%0d mmu_bytemode", i), 32'(mmu_bytemode), 32'(tbl[i].bm));
         chk($sformatf("row%0d if_rdata", i),     if_rdata,          tbl[i].ird);
         chk($sformatf("row%0d mem_rdata", i),    mem_rdata,         tbl[i].mrd);
      end

      // single-cycle access instance: read of 32'hBFD003FC
      @(negedge clk);
      b_reset = 1'b0;
      @(negedge clk);
      b_mem_req = 1'b1; b_mem_we = 1'b0; b_mem_addr = 32'hBFD003FC; b_mmu_rdata = 32'h00000003;
      #1;
      chk("ac1 c0 busy", 32'(b_busy), 32'd0);
      chk("ac1 c0 mem_rdata", b_mem_rdata, 32'd0);
      @(negedge clk); #1;
      chk("ac1 c1 busy", 32'(b_busy), 32'd1);
      chk("ac1 c1 mmu_read", 32'(b_mmu_read), 32'd1);
      chk("ac1 c1 mmu_addr", b_mmu_addr, 32'hBFD003FC);
      chk("ac1 c1 mem_ack", 32'(b_mem_ack), 32'd0);
      @(negedge clk); #1;
      chk("ac1 c2 mem_ack", 32'(b_mem_ack), 32'd1);
      chk("ac1 c2 mmu_read", 32'(b_mmu_read), 32'd0);
      chk("ac1 c2 mem_rdata", b_mem_rdata, 32'h00000003);
      b_mem_req = 1'b0; b_mmu_rdata = 32'hFFFFFFFF;
      @(negedge clk); #1;
      chk("ac1 c3 mem_ack", 32'(b_mem_ack), 32'd0);
      chk("ac1 c3 busy", 32'(b_busy), 32'd0);
      chk("ac1 c3 mem_rdata", b_mem_rdata, 32'h00000003);
      chk("ac1 c3 if_ack", 32'(b_if_ack), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single MMU access port (SRAM, UART, LED/DPY, VGA char registers) between the instruction-fetch requester and the data-memory requester.
- Two-requester, one-resource scheduler, placed between the CPU pipeline and the MMU.
- Latches one request, holds the MMU inputs stable for a fixed number of cycles, then returns the read data with a one-cycle ack.
- The MMU's low-clock-phase strobes therefore always see stable address, data and control.

Parameters:
ACCESS_CYCLES, 2, number of cycles the MMU inputs are held per access; legal range 1..15.
CNT_W, 4, width of the access counter; must hold ACCESS_CYCLES.

Ports:
clk  input  1  system clock; all state changes on its rising edge
reset  input  1  synchronous, active-high reset
if_req  input  1  fetch request, level; held until if_ack
if_addr  input  32  fetch byte address
if_rdata  output  32  fetched word; valid when if_ack=1, held until the next fetch ack
if_ack  output  1  one-cycle completion pulse for fetch
mem_req  input  1  data request, level; held until mem_ack
mem_we  input  1  1=write, 0=read
mem_addr  input  32  data byte address
mem_wdata  input  32  write data
mem_bytemode  input  5  MMU bytemode code (bit4 = zero-extend, bits3:0 = byte enables)
mem_rdata  output  32  load data; valid when mem_ack=1, held until the next data read ack
mem_ack  output  1  one-cycle completion pulse for data
busy  output  1  1 whenever state is not IDLE
mmu_read  output  1  to MMU if_read
mmu_write  output  1  to MMU if_write
mmu_addr  output  32  to MMU addr
mmu_wdata  output  32  to MMU input_data
mmu_bytemode  output  5  to MMU bytemode
mmu_rdata  input  32  from MMU output_data

Behaviour:
- States: IDLE, ACCESS, DONE.
- IDLE:
  - If mem_req=1, latch mem_addr, mem_wdata, mem_bytemode and mem_we; set owner=MEM.
  - Else if if_req=1, latch if_addr; force wdata=0, bytemode=5'b01111 (word read) and we=0; set owner=IF.
  - In either case, load cnt=ACCESS_CYCLES-1 and go to ACCESS.
  - With no request, stay in IDLE.
- ACCESS:
  - mmu_addr, mmu_wdata and mmu_bytemode drive the latched values.
  - mmu_read = ~we; mmu_write = we.
  - When cnt=0: capture mmu_rdata into the owner's rdata register (reads only), then go to DONE. Otherwise decrement cnt.
- DONE:
  - MMU controls are low.
  - The owner's ack is 1 for exactly this cycle.
  - Requests are ignored in this cycle.
  - Go to IDLE next cycle. The requester drops or changes req the cycle after ack.
- Latency: request seen in IDLE at cycle t; MMU driven in cycles t+1..t+ACCESS_CYCLES; ack in cycle t+ACCESS_CYCLES+1.
- Throughput: back-to-back service gives one access per ACCESS_CYCLES+2 cycles.
- Outside ACCESS: mmu_read=0, mmu_write=0, mmu_addr/mmu_wdata=0, mmu_bytemode=5'b01111.
- Data writes: mem_rdata is unchanged and mem_ack still pulses.
- Simultaneous if_req and mem_req in IDLE: MEM wins (default); IF stays pending and is served next.
- Input changes during ACCESS are ignored; the latched values are used.
- A req dropped mid-access does not abort it: the access completes and the ack still pulses.
- ACCESS_CYCLES=1: exactly one ACCESS cycle per access.
- Reset (any state, mid-access included), at the next rising edge:
  - state=IDLE, cnt=0, owner=IF.
  - All MMU outputs go to their idle values.
  - if_ack=0, mem_ack=0, if_rdata=0, mem_rdata=0, busy=0.
  - No ack is issued for the aborted access.

Optional Feature:
- Macro: MEM_ARBITER_ROUND_ROBIN_EN.
- Defined: adds a last_grant register (reset=IF). On a simultaneous request, grant the port that was NOT granted last; a single requester is granted directly. last_grant updates on every grant.
- Undefined: fixed priority, MEM over IF; no last_grant register.

Decomposition:
- Package mem_arbiter_pkg holds:
  - the state encoding: IDLE=2'd0, ACCESS=2'd1, DONE=2'd2;
  - the owner encoding: OWN_IF=1'b0, OWN_MEM=1'b1;
  - BM_WORD=5'b01111 and ACCESS_CYCLES_DEFAULT=2.
- No sub-module: the grant logic is small and stays inline.

Test Plan:
- Reset then if_req=1, if_addr=32'h80000000, mmu_rdata=32'h3C08BFD0 (ACCESS_CYCLES=2) -> mmu_read high for 2 cycles with mmu_addr=32'h80000000; if_ack pulses in cycle 3 with if_rdata=32'h3C08BFD0.
- mem_req=1, mem_we=1, mem_addr=32'h80400010, mem_wdata=32'h000000A5, bytemode=5'b00001 -> mmu_write=1 for 2 cycles with latched values; mem_ack pulses once; mem_rdata unchanged.
- if_req and mem_req raised in the same cycle (macro off) -> MEM served first, IF served immediately after; acks 4 cycles apart.
- Same stimulus with MEM_ARBITER_ROUND_ROBIN_EN and last_grant=MEM -> IF served first, then MEM.
- reset asserted in the 2nd ACCESS cycle of a data read -> next edge gives mmu_read=0, busy=0, no mem_ack, mem_rdata=0.
- ACCESS_CYCLES=1, mem read of 32'hBFD003FC with mmu_rdata=32'h00000003 -> single ACCESS cycle; mem_ack in cycle 2 with mem_rdata=32'h00000003.
